// File: rtl/bs_pe_tile_if.sv
// Command, host row access and neighbour-exchange signals of one bs_pe_tile.
interface bs_pe_tile_if #(
  parameter int SLICE = 4,
  parameter int PE_W  = 2,
  parameter int PE_H  = 2,
  parameter int DEPTH = 1024
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W  = SLICE * PE_W * PE_H;

  // Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready; cmd_* must hold
  // while cmd_valid is high, and cmd_ready stays low from that edge until the tile is idle again.
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [3:0]              cmd_op;
  logic [AW-1:0]           cmd_src_a;
  logic [AW-1:0]           cmd_src_b;
  logic [AW-1:0]           cmd_dst;
  logic [AW:0]             cmd_len;
  logic                    busy;
  logic                    done;
  logic [PE_W*PE_H-1:0]    flag;
  logic                    host_we;
  logic [AW-1:0]           host_addr;
  logic [W-1:0]            host_wdata;
  logic [W-1:0]            host_rdata;
  logic [SLICE*PE_H-1:0]   Ein;
  logic [SLICE*PE_H-1:0]   Win;
  logic [SLICE*PE_W-1:0]   Nin;
  logic [SLICE*PE_W-1:0]   Sin;
  logic [SLICE*PE_H-1:0]   Eout;
  logic [SLICE*PE_H-1:0]   Wout;
  logic [SLICE*PE_W-1:0]   Nout;
  logic [SLICE*PE_W-1:0]   Sout;
  logic [1:0]              dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
    output host_we, host_addr, host_wdata, Ein, Win, Nin, Sin,
    input  cmd_ready, busy, done, flag, host_rdata, Eout, Wout, Nout, Sout, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
    input  host_we, host_addr, host_wdata, Ein, Win, Nin, Sin,
    output cmd_ready, busy, done, flag, host_rdata, Eout, Wout, Nout, Sout, dbg_state
  );
endinterface

// File: rtl/bs_pe_tile.sv
// Bit-sliced PE tile: PE_W x PE_H lanes over one shared register file, driven by a
// row-serial sequencer running ALU ops with per-PE carry chaining and neighbour moves.
module bs_pe_tile #(
  parameter int SLICE = 4,
  parameter int PE_W  = 2,
  parameter int PE_H  = 2,
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  bs_pe_tile_if.slave io
);
  localparam int NPE = PE_W * PE_H;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W   = SLICE * NPE;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_COPY   = 4'd1;
  localparam logic [3:0] OP_MOVE_E = 4'd2;
  localparam logic [3:0] OP_MOVE_W = 4'd3;
  localparam logic [3:0] OP_MOVE_S = 4'd4;
  localparam logic [3:0] OP_MOVE_N = 4'd5;
  localparam logic [3:0] OP_ADD    = 4'd6;
  localparam logic [3:0] OP_SUB    = 4'd7;
  localparam logic [3:0] OP_AND    = 4'd8;
  localparam logic [3:0] OP_OR     = 4'd9;
  localparam logic [3:0] OP_XOR    = 4'd10;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, first_q, first_d;
  logic [3:0]       op_q, op_d;
  logic [NPE-1:0]   flag_q, flag_d, carry_q, carry_d, cout;
  logic [AW-1:0]    addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_w_q, addr_w_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic [W-1:0]     mem [DEPTH];
  logic [W-1:0]     rd_a_q, rd_b_q, res, wd;
  logic [AW-1:0]    ra, wa;
  logic             we, wr_row, op_writes, op_arith;
  logic [SLICE-1:0] nb, b_s;
  logic [SLICE:0]   sum_s;

  function automatic logic [SLICE-1:0] lane(input logic [W-1:0] row, input int r, input int c);
    return row[SLICE*(r*PE_W+c) +: SLICE];
  endfunction

  function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH-1)) ? '0 : a + 1'b1;
  endfunction

  assign op_writes = (op_q != OP_NOP) && (op_q <= OP_XOR);
  assign op_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  // Row data lands one cycle after its address, so RUN writes the previous row and DRAIN the last.
  assign wr_row    = ((state_q == RUN) && !first_q) || (state_q == DRAIN);
  assign ra        = (state_q == IDLE) ? io.host_addr : addr_a_q;

  always_comb begin
    res   = '0;
    cout  = '0;
    nb    = '0;
    b_s   = '0;
    sum_s = '0;
    for (int r = 0; r < PE_H; r++) begin
      for (int c = 0; c < PE_W; c++) begin
        b_s   = (op_q == OP_SUB) ? ~lane(rd_b_q, r, c) : lane(rd_b_q, r, c);
        sum_s = {1'b0, lane(rd_a_q, r, c)} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q[r*PE_W+c]};
        cout[r*PE_W+c] = sum_s[SLICE];
        case (op_q)
          OP_COPY:        nb = lane(rd_a_q, r, c);
          OP_MOVE_E:      nb = (c == 0) ? io.Win[SLICE*r +: SLICE]
                                        : lane(rd_a_q, r, (c > 0) ? c - 1 : 0);
          OP_MOVE_W:      nb = (c == PE_W-1) ? io.Ein[SLICE*r +: SLICE]
                                             : lane(rd_a_q, r, (c < PE_W-1) ? c + 1 : c);
          OP_MOVE_S:      nb = (r == 0) ? io.Nin[SLICE*c +: SLICE]
                                        : lane(rd_a_q, (r > 0) ? r - 1 : 0, c);
          OP_MOVE_N:      nb = (r == PE_H-1) ? io.Sin[SLICE*c +: SLICE]
                                             : lane(rd_a_q, (r < PE_H-1) ? r + 1 : r, c);
          OP_ADD, OP_SUB: nb = sum_s[SLICE-1:0];
          OP_AND:         nb = lane(rd_a_q, r, c) & lane(rd_b_q, r, c);
          OP_OR:          nb = lane(rd_a_q, r, c) | lane(rd_b_q, r, c);
          OP_XOR:         nb = lane(rd_a_q, r, c) ^ lane(rd_b_q, r, c);
          default:        nb = '0;
        endcase
        res[SLICE*(r*PE_W+c) +: SLICE] = nb;
      end
    end
  end

  always_comb begin
    we = 1'b0;
    wa = addr_w_q;
    wd = res;
    if (state_q == IDLE) begin
      we = io.host_we;
      wa = io.host_addr;
      wd = io.host_wdata;
    end else if (wr_row && op_writes) begin
      we = 1'b1;
    end
    if (reset) we = 1'b0;
  end

  // Read-first: a row written and read on the same edge returns its old contents.
  always_ff @(posedge clk) begin
    rd_a_q <= mem[ra];
    rd_b_q <= mem[addr_b_q];
    if (we) mem[wa] <= wd;
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    first_d  = first_q;
    op_d     = op_q;
    flag_d   = flag_q;
    carry_d  = carry_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_w_d = addr_w_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (io.cmd_valid) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          first_d  = 1'b1;
          op_d     = io.cmd_op;
          carry_d  = (io.cmd_op == OP_SUB) ? '1 : '0;
          addr_a_d = io.cmd_src_a;
          addr_b_d = io.cmd_src_b;
          addr_w_d = io.cmd_dst;
          cnt_d    = io.cmd_len;
        end
      end
      RUN: begin
        addr_a_d = inc_addr(addr_a_q);
        addr_b_d = inc_addr(addr_b_q);
        cnt_d    = cnt_q - 1'b1;
        first_d  = 1'b0;
        if (!first_q) begin
          addr_w_d = inc_addr(addr_w_q);
          if (op_arith) carry_d = cout;
        end
        if (cnt_q <= (AW+1)'(1)) begin
          state_d = DRAIN;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (op_arith) begin
          carry_d = cout;
          flag_d  = cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      first_q  <= 1'b0;
      op_q     <= OP_NOP;
      flag_q   <= '0;
      carry_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_w_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      first_q  <= first_d;
      op_q     <= op_d;
      flag_q   <= flag_d;
      carry_q  <= carry_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_w_q <= addr_w_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    io.Eout = '0;
    io.Wout = '0;
    io.Nout = '0;
    io.Sout = '0;
    for (int r = 0; r < PE_H; r++) begin
      io.Eout[SLICE*r +: SLICE] = lane(rd_a_q, r, PE_W-1);
      io.Wout[SLICE*r +: SLICE] = lane(rd_a_q, r, 0);
    end
    for (int c = 0; c < PE_W; c++) begin
      io.Nout[SLICE*c +: SLICE] = lane(rd_a_q, 0, c);
      io.Sout[SLICE*c +: SLICE] = lane(rd_a_q, PE_H-1, c);
    end
  end

  assign io.cmd_ready  = (state_q == IDLE);
  assign io.busy       = busy_q;
  assign io.done       = done_q;
  assign io.flag       = flag_q;
  assign io.host_rdata = rd_a_q;
  assign io.dbg_state  = state_q;
endmodule

// File: tb/tb_bs_pe_tile.sv
// Directed and randomised bench for bs_pe_tile with a reference register-file model and row scoreboard.
module tb_bs_pe_tile;
  localparam int SLICE = 4;
  localparam int PE_W  = 2;
  localparam int PE_H  = 2;
  localparam int DEPTH = 1024;
  localparam int NPE   = PE_W * PE_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int W     = SLICE * NPE;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   ref_mem [DEPTH];
  logic [NPE-1:0] exp_flag = '0;
  logic [3:0]     op_tab [8] = '{4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};

  bs_pe_tile_if #(.SLICE(SLICE), .PE_W(PE_W), .PE_H(PE_H), .DEPTH(DEPTH)) bus ();

  bs_pe_tile #(.SLICE(SLICE), .PE_W(PE_W), .PE_H(PE_H), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver tasks: each starts and ends just after a falling edge.
  task automatic host_write(input int addr, input logic [W-1:0] data);
    bus.host_we    = 1'b1;
    bus.host_addr  = AW'(addr);
    bus.host_wdata = data;
    @(negedge clk);
    bus.host_we    = 1'b0;
    ref_mem[addr]  = data;
  endtask

  task automatic host_read(input int addr, output logic [W-1:0] d);
    bus.host_we   = 1'b0;
    bus.host_addr = AW'(addr);
    @(negedge clk);
    d = bus.host_rdata;
  endtask

  // Reference model: row-serial, read-then-write per row; pushes final dst rows to the scoreboard.
  task automatic model_cmd(input logic [3:0] op, input int sa, input int sb, input int dst, input int len);
    logic [SLICE-1:0] ga [PE_H][PE_W];
    logic [SLICE-1:0] gb [PE_H][PE_W];
    logic [SLICE-1:0] o;
    logic [SLICE:0]   s;
    logic [NPE-1:0]   cy;
    logic [W-1:0]     arow, brow, orow;
    cy = (op == 4'd7) ? '1 : '0;
    for (int i = 0; i < len; i++) begin
      arow = ref_mem[(sa + i) % DEPTH];
      brow = ref_mem[(sb + i) % DEPTH];
      for (int r = 0; r < PE_H; r++)
        for (int c = 0; c < PE_W; c++) begin
          ga[r][c] = arow[SLICE*(r*PE_W+c) +: SLICE];
          gb[r][c] = brow[SLICE*(r*PE_W+c) +: SLICE];
        end
      orow = '0;
      for (int r = 0; r < PE_H; r++)
        for (int c = 0; c < PE_W; c++) begin
          o = '0;
          s = {1'b0, ga[r][c]} + {1'b0, (op == 4'd7) ? ~gb[r][c] : gb[r][c]} + cy[r*PE_W+c];
          case (op)
            1: o = ga[r][c];
            2: if (c == 0) o = bus.Win[SLICE*r +: SLICE]; else o = ga[r][c-1];
            3: if (c == PE_W-1) o = bus.Ein[SLICE*r +: SLICE]; else o = ga[r][c+1];
            4: if (r == 0) o = bus.Nin[SLICE*c +: SLICE]; else o = ga[r-1][c];
            5: if (r == PE_H-1) o = bus.Sin[SLICE*c +: SLICE]; else o = ga[r+1][c];
            6, 7: begin o = s[SLICE-1:0]; cy[r*PE_W+c] = s[SLICE]; end
            8: o = ga[r][c] & gb[r][c];
            9: o = ga[r][c] | gb[r][c];
            10: o = ga[r][c] ^ gb[r][c];
            default: o = '0;
          endcase
          orow[SLICE*(r*PE_W+c) +: SLICE] = o;
        end
      if (op >= 4'd1 && op <= 4'd10) ref_mem[(dst + i) % DEPTH] = orow;
    end
    if (op == 4'd6 || op == 4'd7) exp_flag = cy;
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(dst + i) % DEPTH]);
  endtask

  task automatic run_cmd(input logic [3:0] op, input int sa, input int sb, input int dst, input int len,
                         input bit hw_en, input int hw_addr,
                         output logic [SLICE*PE_W-1:0] nout2, output logic [SLICE*PE_W-1:0] sout2);
    int   busy_n, done_n, done_at, end_at;
    logic ready_after;
    model_cmd(op, sa, sb, dst, len);
    bus.cmd_op    = op;
    bus.cmd_src_a = AW'(sa);
    bus.cmd_src_b = AW'(sb);
    bus.cmd_dst   = AW'(dst);
    bus.cmd_len   = (AW+1)'(len);
    bus.cmd_valid = 1'b1;
    check("accept_ready", W'(bus.cmd_ready), W'(1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0; end_at = 0; ready_after = 1'b0;
    nout2 = '0; sout2 = '0;
    for (int k = 1; k <= len + 8; k++) begin
      if (k == 1 && hw_en) begin
        bus.host_we    = 1'b1;
        bus.host_addr  = AW'(hw_addr);
        bus.host_wdata = ~ref_mem[hw_addr];
      end
      if (k == 2) begin
        bus.host_we = 1'b0;
        nout2 = bus.Nout;
        sout2 = bus.Sout;
      end
      if (!bus.busy) begin
        end_at = k;
        ready_after = bus.cmd_ready;
        break;
      end
      busy_n++;
      if (bus.done) begin
        done_n++;
        done_at = k;
      end
      @(negedge clk);
    end
    bus.host_we = 1'b0;
    check("busy_cycles", W'(busy_n), W'(len + 1));
    check("done_pulses", W'(done_n), W'(1));
    check("done_cycle", W'(done_at), W'(len + 1));
    check("idle_cycle", W'(end_at), W'(len + 2));
    check("ready_after", W'(ready_after), W'(1));
    check("flag", W'(bus.flag), W'(exp_flag));
  endtask

  // Scoreboard: pop expected rows and compare against host reads of the destination.
  task automatic check_rows(input int dst, input int len);
    logic [W-1:0] d, e;
    check("sb_size", W'(exp_q.size()), W'(len));
    for (int i = 0; i < len; i++) begin
      host_read((dst + i) % DEPTH, d);
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check($sformatf("row_%0d", (dst + i) % DEPTH), d, e);
    end
  endtask

  initial begin
    logic [SLICE*PE_W-1:0] n2, s2;
    logic [W-1:0] d, e;
    int done_seen;

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src_a = '0; bus.cmd_src_b = '0;
    bus.cmd_dst = '0; bus.cmd_len = '0; bus.host_we = 1'b0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.Ein = '0; bus.Win = '0; bus.Nin = '0; bus.Sin = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", W'(bus.cmd_ready), W'(1));
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_flag", W'(bus.flag), W'(0));
    check("rst_state", W'(bus.dbg_state), W'(0));

    // Two-row ADD with carry from row 0 into row 1
    host_write(0, 16'h000F); host_write(1, 16'h0000);
    host_write(4, 16'h0001); host_write(5, 16'h0000);
    run_cmd(4'd6, 0, 4, 8, 2, 1'b0, 0, n2, s2);
    check_rows(8, 2);

    // SUB of equal operands: zero result, every carry set
    host_write(10, 16'h1234); host_write(11, 16'h1234);
    run_cmd(4'd7, 10, 11, 12, 1, 1'b0, 0, n2, s2);
    check_rows(12, 1);

    // MOVE_E with west boundary input
    host_write(20, 16'h4321);
    bus.Win = 8'hAB;
    run_cmd(4'd2, 20, 20, 21, 1, 1'b0, 0, n2, s2);
    check_rows(21, 1);

    // MOVE_S with north boundary input; boundary outputs during the data cycle
    host_write(22, 16'h4321);
    bus.Nin = 8'hDC;
    run_cmd(4'd4, 22, 22, 23, 1, 1'b0, 0, n2, s2);
    check("nout", W'(n2), W'(8'h21));
    check("sout", W'(s2), W'(8'h43));
    check_rows(23, 1);

    // Wrap-around COPY with an overlapping lower destination and a host write while busy
    host_write(500, 16'hA5A5);
    host_write(DEPTH-1, W'($urandom)); host_write(0, W'($urandom)); host_write(1, W'($urandom));
    run_cmd(4'd1, DEPTH-1, DEPTH-1, DEPTH-2, 3, 1'b1, 500, n2, s2);
    check_rows(DEPTH-2, 3);
    exp_q.push_back(ref_mem[500]);
    check_rows(500, 1);

    // Randomised ops over multi-row operands
    for (int t = 0; t < 6; t++) begin
      int ln;
      logic [3:0] op;
      ln = $urandom_range(1, 4);
      op = op_tab[$urandom_range(0, 7)];
      bus.Ein = 8'($urandom); bus.Win = 8'($urandom);
      bus.Nin = 8'($urandom); bus.Sin = 8'($urandom);
      for (int i = 0; i < ln; i++) begin
        host_write(100 + i, W'($urandom));
        host_write(110 + i, W'($urandom));
      end
      run_cmd(op, 100, 110, 120, ln, 1'b0, 0, n2, s2);
      check_rows(120, ln);
    end

    // NOP and reserved opcode: no writes, done still pulses, flag kept
    run_cmd(4'd0, 100, 110, 120, 2, 1'b0, 0, n2, s2);
    check_rows(120, 2);
    run_cmd(4'd13, 100, 110, 120, 2, 1'b0, 0, n2, s2);
    check_rows(120, 2);

    // Reset in the middle of an 8-row COPY
    for (int i = 0; i < 8; i++) begin
      host_write(200 + i, W'($urandom));
      host_write(210 + i, W'($urandom));
    end
    for (int i = 3; i < 8; i++) exp_q.push_back(ref_mem[200 + i]);
    bus.cmd_op = 4'd1; bus.cmd_src_a = AW'(210); bus.cmd_src_b = AW'(210);
    bus.cmd_dst = AW'(200); bus.cmd_len = (AW+1)'(8); bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    done_seen = 0;
    for (int k = 1; k < 4; k++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    if (bus.done) done_seen++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", W'(bus.busy), W'(0));
    check("mid_rst_ready", W'(bus.cmd_ready), W'(1));
    check("mid_rst_flag", W'(bus.flag), W'(0));
    for (int k = 0; k < 4; k++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check("mid_rst_done", W'(done_seen), W'(0));
    check("mid_rst_sb", W'(exp_q.size()), W'(5));
    for (int i = 3; i < 8; i++) begin
      host_read(200 + i, d);
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check($sformatf("mid_rst_row_%0d", 200 + i), d, e);
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
